// File: rtl/branch_target_buffer_if.sv
// Bundle between the pipeline and the branch target buffer.
//
// Signals:
//   pc_if          fetch-stage PC to look up
//   branch_id      ID-stage instruction is a branch or jump (statistics only)
//   pc_four_mem    PC+4 of the MEM-stage instruction
//   branch_mem     MEM-stage instruction is a branch or jump
//   br_sel_mem     resolved direction (1 = taken)
//   alu_data_mem   resolved target address
//   predicted_pc_o predicted next PC
//   hit_o          prediction is taken, select predicted_pc_o
//   mis_hit_o      MEM-stage branch was mispredicted
//
// Modports: master = pipeline side, slave = BTB side.
interface branch_target_buffer_if;
  logic [31:0] pc_if;
  logic        branch_id;
  logic [31:0] pc_four_mem;
  logic        branch_mem;
  logic        br_sel_mem;
  logic [31:0] alu_data_mem;
  logic [31:0] predicted_pc_o;
  logic        hit_o;
  logic        mis_hit_o;

  modport master (
    output pc_if, branch_id, pc_four_mem, branch_mem, br_sel_mem, alu_data_mem,
    input  predicted_pc_o, hit_o, mis_hit_o
  );

  modport slave (
    input  pc_if, branch_id, pc_four_mem, branch_mem, br_sel_mem, alu_data_mem,
    output predicted_pc_o, hit_o, mis_hit_o
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Lookup in IF is combinational; the table is trained by
// the resolved branch in MEM, which is also checked for misprediction.
//
// Ports:
//   clk_i   clock, table updates on the rising edge
//   rst_ni  asynchronous active-low reset, clears the table
//   btb     branch_target_buffer_if.slave (lookup, resolve and result signals)
//   branch_cnt_o, mispredict_cnt_o   statistics counters, present only when
//                                    the BTB_STATS_EN macro is defined
module branch_target_buffer #(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 32 - 2 - IDX_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  branch_target_buffer_if.slave    btb
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]              branch_cnt_o,
  output logic [31:0]              mispredict_cnt_o
`endif
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0]   idx_if, idx_m;
  logic [TAG_W-1:0]   tag_if, tag_m;
  logic [31:0]        bpc;
  logic               hit;
  logic               m_tag_hit;
  logic               pred_taken;
  logic               mis_hit;
  logic [1:0]         ctr_d;
  logic [31:0]        target_d;

  // Fetch-side lookup against the pre-update table.
  assign idx_if = btb.pc_if[IDX_W+1:2];
  assign tag_if = btb.pc_if[31:IDX_W+2];
  assign hit    = valid_q[idx_if] && (tag_q[idx_if] == tag_if) && ctr_q[idx_if][1];

  assign btb.hit_o          = hit;
  assign btb.predicted_pc_o = hit ? target_q[idx_if] : btb.pc_if + 32'd4;

  // Resolve-side check, also against the pre-update table.
  assign bpc        = btb.pc_four_mem - 32'd4;
  assign idx_m      = bpc[IDX_W+1:2];
  assign tag_m      = bpc[31:IDX_W+2];
  assign m_tag_hit  = valid_q[idx_m] && (tag_q[idx_m] == tag_m);
  assign pred_taken = m_tag_hit && ctr_q[idx_m][1];

  // Gated with rst_ni so a branch sitting in MEM during reset cannot flush.
  assign mis_hit = rst_ni && btb.branch_mem &&
                   ((pred_taken != btb.br_sel_mem) ||
                    (pred_taken && btb.br_sel_mem && (target_q[idx_m] != btb.alu_data_mem)));
  assign btb.mis_hit_o = mis_hit;

  // New contents of the MEM-stage entry.
  always_comb begin
    ctr_d    = ctr_q[idx_m];
    target_d = target_q[idx_m];
    if (!m_tag_hit) begin
      ctr_d    = btb.br_sel_mem ? 2'b10 : 2'b01;
      target_d = btb.alu_data_mem;
    end else if (btb.br_sel_mem) begin
      if (ctr_q[idx_m] != 2'b11) ctr_d = ctr_q[idx_m] + 2'd1;
      target_d = btb.alu_data_mem;
    end else begin
      if (ctr_q[idx_m] != 2'b00) ctr_d = ctr_q[idx_m] - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else if (btb.branch_mem) begin
      valid_q[idx_m]  <= 1'b1;
      tag_q[idx_m]    <= tag_m;
      target_q[idx_m] <= target_d;
      ctr_q[idx_m]    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  assign branch_cnt_d     = branch_cnt_q + {31'd0, btb.branch_id};
  assign mispredict_cnt_d = mispredict_cnt_q + {31'd0, mis_hit};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  logic unused_branch_id;
  assign unused_branch_id = btb.branch_id;
`endif

  // Instructions are word aligned; the byte-offset bits carry no information.
  logic [3:0] unused_pc_lsb;
  assign unused_pc_lsb = {btb.pc_if[1:0], bpc[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  branch_target_buffer_if intf ();

`ifdef BTB_STATS_EN
  logic [31:0] branch_cnt, mispredict_cnt;
`endif

  branch_target_buffer dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btb    (intf.slave)
`ifdef BTB_STATS_EN
    ,
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc_if;
    logic        bm;
    logic [31:0] pcf;
    logic        sel;
    logic [31:0] alu;
    logic        hit;
    logic [31:0] pred;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  // Reference model: each slot remembers the full branch PC it was trained on.
  bit          m_valid [64];
  logic [31:0] m_pc    [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] pc_if, input logic bm, input logic [31:0] pcf,
                     input logic sel, input logic [31:0] alu, input logic hit,
                     input logic [31:0] pred, input logic mis);
    vec_t v;
    v.pc_if = pc_if; v.bm = bm; v.pcf = pcf; v.sel = sel; v.alu = alu;
    v.hit = hit; v.pred = pred; v.mis = mis;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] pc_if, input logic bm, input logic [31:0] pcf,
                       input logic sel, input logic [31:0] alu);
    intf.pc_if        = pc_if;
    intf.branch_mem   = bm;
    intf.pc_four_mem  = pcf;
    intf.br_sel_mem   = sel;
    intf.alu_data_mem = alu;
    intf.branch_id    = bm;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
  endtask

  function automatic bit model_taken(input logic [31:0] pc);
    int i = int'((pc >> 2) % 64);
    return m_valid[i] && (m_pc[i][31:2] == pc[31:2]) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_pred(input logic [31:0] pc);
    int i = int'((pc >> 2) % 64);
    return model_taken(pc) ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic bit model_mis(input bit bm, input logic [31:0] pcf, input bit sel,
                                   input logic [31:0] alu);
    logic [31:0] bpc = pcf - 32'd4;
    bit pt = model_taken(bpc);
    if (!bm) return 1'b0;
    if (pt != sel) return 1'b1;
    return pt && sel && (model_pred(bpc) != alu);
  endfunction

  task automatic model_update(input logic [31:0] pcf, input bit sel, input logic [31:0] alu);
    logic [31:0] bpc = pcf - 32'd4;
    int i = int'((bpc >> 2) % 64);
    if (m_valid[i] && m_pc[i][31:2] == bpc[31:2]) begin
      if (sel) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = alu;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else begin
      m_valid[i] = 1'b1;
      m_pc[i]    = bpc;
      m_tgt[i]   = alu;
      m_ctr[i]   = sel ? 2 : 1;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(32'h100, 1'b1, 32'h104, 1'b1, 32'h080);
    #2;
    check("reset_hit", {31'd0, intf.hit_o}, 32'd0);
    check("reset_pred", intf.predicted_pc_o, 32'h104);
    check("reset_mis", {31'd0, intf.mis_hit_o}, 32'd0);
    do_reset();

    //  pc_if    bm   pc_four   sel   alu       hit   pred      mis
    add(32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h104, 1'b0); // cold lookup
    add(32'h100, 1'b1, 32'h104, 1'b1, 32'h080, 1'b0, 32'h104, 1'b1); // cold taken
    add(32'h100, 1'b1, 32'h104, 1'b1, 32'h080, 1'b1, 32'h080, 1'b0); // ctr 10->11
    add(32'h100, 1'b1, 32'h104, 1'b1, 32'h080, 1'b1, 32'h080, 1'b0); // saturate
    add(32'h100, 1'b1, 32'h104, 1'b1, 32'h080, 1'b1, 32'h080, 1'b0); // saturate
    add(32'h100, 1'b1, 32'h104, 1'b0, 32'h104, 1'b1, 32'h080, 1'b1); // 11->10
    add(32'h100, 1'b1, 32'h104, 1'b0, 32'h104, 1'b1, 32'h080, 1'b1); // 10->01
    add(32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h104, 1'b0); // weakly NT
    add(32'h100, 1'b1, 32'h104, 1'b1, 32'h0C0, 1'b0, 32'h104, 1'b1); // 01->10, tgt C0
    add(32'h100, 1'b0, 32'h104, 1'b0, 32'h000, 1'b1, 32'h0C0, 1'b0); // bm=0 no mis
    add(32'h100, 1'b1, 32'h104, 1'b1, 32'h0E0, 1'b1, 32'h0C0, 1'b1); // target change
    add(32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1, 32'h0E0, 1'b0);
    add(32'h200, 1'b1, 32'h204, 1'b0, 32'h204, 1'b0, 32'h204, 1'b0); // cold NT, evicts 0x100
    add(32'h200, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h204, 1'b0);
    add(32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h104, 1'b0); // conflict miss
    add(32'h200, 1'b1, 32'h204, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1); // same-cycle: old value
    add(32'h200, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1, 32'h300, 1'b0); // new value visible
    add(32'h104, 1'b1, 32'h108, 1'b1, 32'h400, 1'b0, 32'h108, 1'b1); // index 1 cold
    add(32'h104, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1, 32'h400, 1'b0);
    add(32'h200, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1, 32'h300, 1'b0);

    foreach (vecs[k]) begin
      drive(vecs[k].pc_if, vecs[k].bm, vecs[k].pcf, vecs[k].sel, vecs[k].alu);
      @(negedge clk_i);
      check($sformatf("vec%0d_hit", k), {31'd0, intf.hit_o}, {31'd0, vecs[k].hit});
      check($sformatf("vec%0d_pred", k), intf.predicted_pc_o, vecs[k].pred);
      check($sformatf("vec%0d_mis", k), {31'd0, intf.mis_hit_o}, {31'd0, vecs[k].mis});
      @(posedge clk_i);
      #1;
    end

    // Mid-run asynchronous reset with an update pending in MEM.
    drive(32'h200, 1'b1, 32'h204, 1'b1, 32'h500);
    @(negedge clk_i);
    check("prereset_hit", {31'd0, intf.hit_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("midreset_hit", {31'd0, intf.hit_o}, 32'd0);
    check("midreset_pred", intf.predicted_pc_o, 32'h204);
    check("midreset_mis", {31'd0, intf.mis_hit_o}, 32'd0);
    @(posedge clk_i);
    #1;
    drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("postreset_hit200", {31'd0, intf.hit_o}, 32'd0);
    check("postreset_pred200", intf.predicted_pc_o, 32'h204);
    drive(32'h104, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("postreset_hit104", {31'd0, intf.hit_o}, 32'd0);
    @(posedge clk_i);
    #1;

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc_if, bpc, alu;
      bit bm, sel;
      pc_if = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
      bpc   = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
      alu   = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
      bm    = ($urandom_range(0, 2) != 0);
      sel   = $urandom_range(0, 1) == 1;
      drive(pc_if, bm, bpc + 32'd4, sel, alu);
      @(negedge clk_i);
      check("rnd_hit", {31'd0, intf.hit_o}, {31'd0, model_taken(pc_if)});
      check("rnd_pred", intf.predicted_pc_o, model_pred(pc_if));
      check("rnd_mis", {31'd0, intf.mis_hit_o}, {31'd0, model_mis(bm, bpc + 32'd4, sel, alu)});
      @(posedge clk_i);
      if (bm) model_update(bpc + 32'd4, sel, alu);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
